ram_port_b_arbiter: RTL and testbench

Shares the second port of the 32K×8 data RAM between two external requesters: requester 0, the display/readout scanner, and requester 1, the host debug loader. The CPU keeps exclusive use of port A, and this block is the only driver of port B. It uses round-robin arbitration with an optional bounded burst lock. Each grant issues one RAM access. Read data is routed back to the requester that issued the read, one cycle later.

---
 rtl/arm_mem_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 27 ++
 rtl/ram_port_b_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_port_b_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the data RAM port-B arbitration logic.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package arm_mem_pkg;

  localparam int RAM_AW = 15;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } arb_state_e;

  // Tag for an outstanding read: which requester gets the q_b data next cycle.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick with an optional forced owner.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; a requester without a grant simply keeps requesting.
// Ports: i_req[1:0] requests, i_last most recent grantee,
//        i_force_en/i_force_id owner that wins whenever it requests,
//        o_gnt[1:0] one-hot grant (all zero only when nothing requests).
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_force_en,
  input  logic       i_force_id,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_force_en && i_req[i_force_id]) begin
      o_gnt = i_force_id ? 2'b10 : 2'b01;
    end else if (&i_req) begin
      // Contention: the side that was not served last wins.
      o_gnt = i_last ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/ram_port_b_arbiter.sv
// Shares data RAM port B between the display scanner (r0) and host debug loader (r1).
// Latency: grant is combinational (0 cycles); read data returns 1 cycle after the grant edge.
// Backpressure: a requester holds its request until it sees gnt; no-grant cycles stall it.
// Ports: clk/rst (sync active-high); rN_req/we/lock/addr/wdata in, rN_gnt/rvalid/rdata out
//        for N = 0,1; ram_address_b/ram_data_b/ram_wren_b to the RAM, ram_q_b from it.
module ram_port_b_arbiter
  import arm_mem_pkg::*;
#(
  parameter int AW        = RAM_AW,
  parameter int DW        = RAM_DW,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] ram_address_b,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_wren_b,
  input  logic [DW-1:0] ram_q_b
);

  // The grant that enters a lock is the first of the burst, so the lock stops
  // forcing once MAX_BURST-1 further contested grants have been counted.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [7:0] r_burst_cnt;
  logic [7:0] w_burst_cnt_nxt;
  logic       r_last;
  rd_tag_t    r_tag;

  logic [1:0] w_pick;
  logic [1:0] w_gnt;
  logic       w_limit;
  logic       w_force_en;
  logic       w_force_id;
  logic       w_sel;
  logic       w_we_sel;

  // Lock owner is forced unless its burst budget is spent with the other side waiting.
  always_comb begin
    w_limit    = 1'b0;
    w_force_en = 1'b0;
    w_force_id = 1'b0;
    case (r_state)
      LOCK0: begin
        w_limit    = r1_req && (r_burst_cnt >= BURST_LAST);
        w_force_en = !w_limit;
        w_force_id = 1'b0;
      end
      LOCK1: begin
        w_limit    = r0_req && (r_burst_cnt >= BURST_LAST);
        w_force_en = !w_limit;
        w_force_id = 1'b1;
      end
      default: ;
    endcase
  end

  rr_pick2 u_pick (
    .i_req      ({r1_req, r0_req}),
    .i_last     (r_last),
    .i_force_en (w_force_en),
    .i_force_id (w_force_id),
    .o_gnt      (w_pick)
  );

  // No accesses are issued while reset is held.
  assign w_gnt    = rst ? 2'b00 : w_pick;
  assign w_sel    = w_gnt[1];
  assign w_we_sel = w_sel ? r1_we : r0_we;

  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_gnt[0] && r0_lock) begin
          w_state_nxt = LOCK0;
        end else if (w_gnt[1] && r1_lock) begin
          w_state_nxt = LOCK1;
        end
      end
      LOCK0: begin
        if (w_limit || !r0_req || !r0_lock) begin
          w_state_nxt = (w_gnt[1] && r1_lock) ? LOCK1 : IDLE;
        end else if (r1_req) begin
          w_burst_cnt_nxt = r_burst_cnt + 8'd1;
        end
      end
      LOCK1: begin
        if (w_limit || !r1_req || !r1_lock) begin
          w_state_nxt = (w_gnt[0] && r0_lock) ? LOCK0 : IDLE;
        end else if (r0_req) begin
          w_burst_cnt_nxt = r_burst_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Every lock entry and exit starts the burst count afresh.
    if (w_state_nxt != r_state) begin
      w_burst_cnt_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_burst_cnt <= 8'd0;
      r_last      <= 1'b1;
      r_tag       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      if (|w_gnt) begin
        r_last <= w_gnt[1];
      end
      r_tag.valid <= (|w_gnt) && !w_we_sel;
      r_tag.id    <= w_gnt[1];
    end
  end

  assign r0_gnt = w_gnt[0];
  assign r1_gnt = w_gnt[1];

  assign ram_address_b = w_sel ? r1_addr : r0_addr;
  assign ram_data_b    = w_sel ? r1_wdata : r0_wdata;
  assign ram_wren_b    = (|w_gnt) && w_we_sel;

  assign r0_rvalid = r_tag.valid && !r_tag.id;
  assign r1_rvalid = r_tag.valid && r_tag.id;
  assign r0_rdata  = r0_rvalid ? ram_q_b : '0;
  assign r1_rdata  = r1_rvalid ? ram_q_b : '0;

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Directed bench for ram_port_b_arbiter with a behavioural 32Kx8 port-B RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_port_b_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
  logic [14:0] r0_addr;
  logic [7:0]  r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [14:0] r1_addr;
  logic [7:0]  r1_wdata, r1_rdata;
  logic [14:0] ram_address_b;
  logic [7:0]  ram_data_b;
  logic        ram_wren_b;
  logic [7:0]  ram_q_b;

  logic [7:0]  mem [0:32767];
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [7:0]  pre_dat = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_b_arbiter #(.AW(15), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_address_b(ram_address_b), .ram_data_b(ram_data_b),
    .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b)
  );

  // Port-B RAM: registered address, q_b valid the cycle after the address edge.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
    ram_q_b <= mem[ram_address_b];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    pre_we = 1; pre_addr = a; pre_dat = d;
    step();
    pre_we = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    r0_req = 1; r0_we = 1; r1_req = 1;
    step();
    step();
    @(negedge clk);
    n_cmp++; if (r0_gnt !== 1'b0) begin n_err++; $display("FAIL reset_r0_gnt: got %b want 0", r0_gnt); end
    n_cmp++; if (r1_gnt !== 1'b0) begin n_err++; $display("FAIL reset_r1_gnt: got %b want 0", r1_gnt); end
    n_cmp++; if (ram_wren_b !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", ram_wren_b); end
    n_cmp++; if (r0_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_r0_rvalid: got %b want 0", r0_rvalid); end
    n_cmp++; if (r1_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_r1_rvalid: got %b want 0", r1_rvalid); end
    n_cmp++; if (r0_rdata !== 8'h00) begin n_err++; $display("FAIL reset_r0_rdata: got %h want 00", r0_rdata); end
    n_cmp++; if (r1_rdata !== 8'h00) begin n_err++; $display("FAIL reset_r1_rdata: got %h want 00", r1_rdata); end
    idle_inputs();
    step();
    rst = 0;
  endtask

  task automatic test_single_read;
    do_reset();
    preload(15'h0010, 8'hA5);
    r0_req = 1; r0_we = 0; r0_addr = 15'h0010;
    @(negedge clk);
    n_cmp++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL single_r0_gnt: got %b want 1", r0_gnt); end
    n_cmp++; if (r1_gnt !== 1'b0) begin n_err++; $display("FAIL single_r1_gnt: got %b want 0", r1_gnt); end
    n_cmp++; if (ram_address_b !== 15'h0010) begin n_err++; $display("FAIL single_addr: got %h want 0010", ram_address_b); end
    n_cmp++; if (ram_wren_b !== 1'b0) begin n_err++; $display("FAIL single_wren: got %b want 0", ram_wren_b); end
    step();
    r0_req = 0;
    @(negedge clk);
    n_cmp++; if (r0_rvalid !== 1'b1) begin n_err++; $display("FAIL single_r0_rvalid: got %b want 1", r0_rvalid); end
    n_cmp++; if (r0_rdata !== 8'hA5) begin n_err++; $display("FAIL single_r0_rdata: got %h want a5", r0_rdata); end
    n_cmp++; if (r1_rvalid !== 1'b0) begin n_err++; $display("FAIL single_r1_rvalid: got %b want 0", r1_rvalid); end
    n_cmp++; if (r1_rdata !== 8'h00) begin n_err++; $display("FAIL single_r1_rdata: got %h want 00", r1_rdata); end
    step();
  endtask

  task automatic test_contention;
    int k0, k1, exp_g, prev;
    logic [7:0] prev_dat;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      preload(15'(32'h200 + i), 8'(32'h10 + i));
      preload(15'(32'h300 + i), 8'(32'h80 + i));
    end
    k0 = 0; k1 = 0; prev_dat = '0;
    for (int c = 0; c < 6; c++) begin
      r0_req = 1; r0_we = 0; r0_addr = 15'(32'h200 + k0);
      r1_req = 1; r1_we = 0; r1_addr = 15'(32'h300 + k1);
      exp_g = c % 2;
      @(negedge clk);
      n_cmp++; if (r0_gnt !== (exp_g == 0)) begin n_err++; $display("FAIL cont_r0_gnt c=%0d: got %b want %b", c, r0_gnt, exp_g == 0); end
      n_cmp++; if (r1_gnt !== (exp_g == 1)) begin n_err++; $display("FAIL cont_r1_gnt c=%0d: got %b want %b", c, r1_gnt, exp_g == 1); end
      if (c > 0) begin
        prev = 1 - exp_g;
        n_cmp++; if (r0_rvalid !== (prev == 0)) begin n_err++; $display("FAIL cont_r0_rvalid c=%0d: got %b want %b", c, r0_rvalid, prev == 0); end
        n_cmp++; if (r1_rvalid !== (prev == 1)) begin n_err++; $display("FAIL cont_r1_rvalid c=%0d: got %b want %b", c, r1_rvalid, prev == 1); end
        n_cmp++; if ((prev == 0 ? r0_rdata : r1_rdata) !== prev_dat) begin
          n_err++; $display("FAIL cont_rdata c=%0d: got %h want %h", c, (prev == 0 ? r0_rdata : r1_rdata), prev_dat);
        end
      end
      if (exp_g == 0) begin prev_dat = 8'(32'h10 + k0); k0++; end
      else begin prev_dat = 8'(32'h80 + k1); k1++; end
      step();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (r1_rvalid !== 1'b1) begin n_err++; $display("FAIL cont_last_r1_rvalid: got %b want 1", r1_rvalid); end
    n_cmp++; if (r1_rdata !== prev_dat) begin n_err++; $display("FAIL cont_last_r1_rdata: got %h want %h", r1_rdata, prev_dat); end
    n_cmp++; if (r0_rvalid !== 1'b0) begin n_err++; $display("FAIL cont_last_r0_rvalid: got %b want 0", r0_rvalid); end
    step();
  endtask

  task automatic test_write_readback;
    do_reset();
    r1_req = 1; r1_we = 1; r1_addr = 15'h7FFF; r1_wdata = 8'h3C;
    @(negedge clk);
    n_cmp++; if (r1_gnt !== 1'b1) begin n_err++; $display("FAIL wr_r1_gnt: got %b want 1", r1_gnt); end
    n_cmp++; if (ram_wren_b !== 1'b1) begin n_err++; $display("FAIL wr_wren0: got %b want 1", ram_wren_b); end
    n_cmp++; if (ram_address_b !== 15'h7FFF) begin n_err++; $display("FAIL wr_addr: got %h want 7fff", ram_address_b); end
    n_cmp++; if (ram_data_b !== 8'h3C) begin n_err++; $display("FAIL wr_data: got %h want 3c", ram_data_b); end
    step();
    r1_we = 0; r1_wdata = 8'h00;
    @(negedge clk);
    n_cmp++; if (r1_gnt !== 1'b1) begin n_err++; $display("FAIL rd_r1_gnt: got %b want 1", r1_gnt); end
    n_cmp++; if (ram_wren_b !== 1'b0) begin n_err++; $display("FAIL rd_wren1: got %b want 0", ram_wren_b); end
    n_cmp++; if (r1_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 0", r1_rvalid); end
    step();
    r1_req = 0;
    @(negedge clk);
    n_cmp++; if (r1_rvalid !== 1'b1) begin n_err++; $display("FAIL rb_r1_rvalid: got %b want 1", r1_rvalid); end
    n_cmp++; if (r1_rdata !== 8'h3C) begin n_err++; $display("FAIL rb_r1_rdata: got %h want 3c", r1_rdata); end
    n_cmp++; if (ram_wren_b !== 1'b0) begin n_err++; $display("FAIL rb_wren2: got %b want 0", ram_wren_b); end
    step();
  endtask

  task automatic test_burst;
    logic exp1;
    do_reset();
    r0_req = 1; r0_lock = 1; r1_req = 1;
    // Lock owner gets 4 in a row, then r1 once, then r0 relocks for another 4.
    for (int c = 0; c < 10; c++) begin
      exp1 = (c == 4) || (c == 9);
      @(negedge clk);
      n_cmp++; if (r0_gnt !== !exp1) begin n_err++; $display("FAIL burst_r0_gnt c=%0d: got %b want %b", c, r0_gnt, !exp1); end
      n_cmp++; if (r1_gnt !== exp1) begin n_err++; $display("FAIL burst_r1_gnt c=%0d: got %b want %b", c, r1_gnt, exp1); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_unopposed;
    int n0, further;
    logic got;
    do_reset();
    r0_req = 1; r0_lock = 1;
    n0 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (r0_gnt === 1'b1 && r1_gnt === 1'b0) n0++;
      step();
    end
    n_cmp++; if (n0 != 40) begin n_err++; $display("FAIL unopp_grants: got %0d want 40", n0); end
    n_cmp++; if (dut.r_burst_cnt !== 8'd0) begin n_err++; $display("FAIL unopp_burst_cnt: got %0d want 0", dut.r_burst_cnt); end
    r1_req = 1;
    further = 0; got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (r1_gnt === 1'b1) got = 1;
      else if (r0_gnt === 1'b1) further++;
      step();
    end
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL unopp_r1_granted: got %b want 1", got); end
    n_cmp++; if (further > 4) begin n_err++; $display("FAIL unopp_further: got %0d want <=4", further); end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    preload(15'h0010, 8'hA5);
    r0_req = 1; r0_we = 0; r0_addr = 15'h0010;
    @(negedge clk);
    n_cmp++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL mid_r0_gnt: got %b want 1", r0_gnt); end
    step();
    rst = 1;
    @(negedge clk);
    n_cmp++; if (r0_gnt !== 1'b0) begin n_err++; $display("FAIL mid_gnt_in_rst: got %b want 0", r0_gnt); end
    step();
    rst = 0;
    r0_req = 1; r0_we = 0; r0_addr = 15'h0011;
    r1_req = 1; r1_we = 0; r1_addr = 15'h0022;
    @(negedge clk);
    n_cmp++; if (r0_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_r0_rvalid: got %b want 0", r0_rvalid); end
    n_cmp++; if (ram_wren_b !== 1'b0) begin n_err++; $display("FAIL mid_wren: got %b want 0", ram_wren_b); end
    n_cmp++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL mid_first_r0_gnt: got %b want 1", r0_gnt); end
    n_cmp++; if (r1_gnt !== 1'b0) begin n_err++; $display("FAIL mid_first_r1_gnt: got %b want 0", r1_gnt); end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_single_read();
    test_contention();
    test_write_readback();
    test_burst();
    test_unopposed();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
